// File: rtl/writeback_stage_if.sv
// rtl/writeback_stage_if.sv - MEM/WB handshake and register-file write bundle for writeback_stage
//
// Purpose : groups the pipeline-control, MEM-stage result and write-back
//           signals of writeback_stage so the stage and its driver share one port.
// Params  : CNT_W - width of RetiredCount (must match writeback_stage.CNT_W)
// Modports: slave  - the write-back stage (consumes MEM fields, drives WB outputs)
//           master - the pipeline side (drives MEM fields, observes WB outputs)
// Signals : Stall, Flush, Valid_MEM, RegWrite_MEM, MemToReg_MEM, R_Width_MEM,
//           LoadUnsigned_MEM, RegDestSelected_MEM, ALUResult_MEM, ReadData_MEM,
//           RegDestSelected_WB, RegWriteData_WB, RegWrite_WB, RetiredCount,
//           plus ReadReg1/2_ID, Reg_Data1/2_RF, Reg_Data1/2_Fwd when BYPASS_EN is defined.
interface writeback_stage_if #(
   parameter int CNT_W = 32
);
   logic             Stall;
   logic             Flush;
   logic             Valid_MEM;
   logic             RegWrite_MEM;
   logic             MemToReg_MEM;
   logic [1:0]       R_Width_MEM;
   logic             LoadUnsigned_MEM;
   logic [4:0]       RegDestSelected_MEM;
   logic [31:0]      ALUResult_MEM;
   logic [31:0]      ReadData_MEM;
   logic [4:0]       RegDestSelected_WB;
   logic [31:0]      RegWriteData_WB;
   logic             RegWrite_WB;
   logic [CNT_W-1:0] RetiredCount;
`ifdef BYPASS_EN
   logic [4:0]       ReadReg1_ID;
   logic [4:0]       ReadReg2_ID;
   logic [31:0]      Reg_Data1_RF;
   logic [31:0]      Reg_Data2_RF;
   logic [31:0]      Reg_Data1_Fwd;
   logic [31:0]      Reg_Data2_Fwd;
`endif

   modport slave (
      input  Stall, Flush, Valid_MEM, RegWrite_MEM, MemToReg_MEM, R_Width_MEM,
             LoadUnsigned_MEM, RegDestSelected_MEM, ALUResult_MEM, ReadData_MEM,
      output RegDestSelected_WB, RegWriteData_WB, RegWrite_WB, RetiredCount
`ifdef BYPASS_EN
      , input  ReadReg1_ID, ReadReg2_ID, Reg_Data1_RF, Reg_Data2_RF
      , output Reg_Data1_Fwd, Reg_Data2_Fwd
`endif
   );

   modport master (
      output Stall, Flush, Valid_MEM, RegWrite_MEM, MemToReg_MEM, R_Width_MEM,
             LoadUnsigned_MEM, RegDestSelected_MEM, ALUResult_MEM, ReadData_MEM,
      input  RegDestSelected_WB, RegWriteData_WB, RegWrite_WB, RetiredCount
`ifdef BYPASS_EN
      , output ReadReg1_ID, ReadReg2_ID, Reg_Data1_RF, Reg_Data2_RF
      , input  Reg_Data1_Fwd, Reg_Data2_Fwd
`endif
   );
endinterface

// File: rtl/writeback_stage.sv
// rtl/writeback_stage.sv - MEM/WB pipeline register with load extraction, write enable and retire counter
//
// Purpose : latches MEM-stage results, forms the register-file write data
//           (ALU result or word/half/byte load with sign/zero extension),
//           drives the decode-stage write port and counts retired instructions.
// Params  : DATA_W - datapath width, fixed at 32 (byte/half lanes are hard-wired)
//           CNT_W  - RetiredCount width (must match the interface's CNT_W)
// Ports   : Clock - rising-edge clock
//           Reset - synchronous, active-low reset
//           bus   - writeback_stage_if.slave (MEM inputs, WB outputs, optional bypass)
// Option  : BYPASS_EN - when defined, adds combinational forwarding of the pending
//           write onto the two decode-stage read operands.
module writeback_stage #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 32
) (
   input  logic               Clock,
   input  logic               Reset,
   writeback_stage_if.slave   bus
);

   logic              valid_q,    valid_d;
   logic              regwrite_q, regwrite_d;
   logic [4:0]        dest_q,     dest_d;
   logic [DATA_W-1:0] data_q,     data_d;
   logic [CNT_W-1:0]  cnt_q,      cnt_d;

   logic [15:0]       half_w;
   logic [7:0]        byte_w;
   logic [DATA_W-1:0] load_w;

   // Load extraction happens in MEM so that WB holds finished write data.
   always_comb begin
      half_w = bus.ALUResult_MEM[1] ? bus.ReadData_MEM[31:16] : bus.ReadData_MEM[15:0];
      byte_w = bus.ReadData_MEM[7:0];
      case (bus.ALUResult_MEM[1:0])
         2'd0:    byte_w = bus.ReadData_MEM[7:0];
         2'd1:    byte_w = bus.ReadData_MEM[15:8];
         2'd2:    byte_w = bus.ReadData_MEM[23:16];
         default: byte_w = bus.ReadData_MEM[31:24];
      endcase

      load_w = bus.ReadData_MEM;
      case (bus.R_Width_MEM)
         2'b01:   load_w = bus.LoadUnsigned_MEM ? {16'h0000, half_w}
                                                : {{16{half_w[15]}}, half_w};
         2'b10:   load_w = bus.LoadUnsigned_MEM ? {24'h000000, byte_w}
                                                : {{24{byte_w[7]}}, byte_w};
         default: load_w = bus.ReadData_MEM;
      endcase
   end

   // Next state: Flush beats Stall, Stall beats capture. Reset is applied in the register.
   always_comb begin
      valid_d    = valid_q;
      regwrite_d = regwrite_q;
      dest_d     = dest_q;
      data_d     = data_q;
      cnt_d      = cnt_q;
      if (bus.Flush) begin
         valid_d = 1'b0;
      end else if (!bus.Stall) begin
         valid_d    = bus.Valid_MEM;
         regwrite_d = bus.RegWrite_MEM;
         dest_d     = bus.RegDestSelected_MEM;
         data_d     = bus.MemToReg_MEM ? load_w : bus.ALUResult_MEM;
         if (bus.Valid_MEM) begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge Clock) begin
      if (!Reset) begin
         valid_q    <= 1'b0;
         regwrite_q <= 1'b0;
         dest_q     <= 5'd0;
         data_q     <= '0;
         cnt_q      <= '0;
      end else begin
         valid_q    <= valid_d;
         regwrite_q <= regwrite_d;
         dest_q     <= dest_d;
         data_q     <= data_d;
         cnt_q      <= cnt_d;
      end
   end

   // A held write during Stall stays asserted; rewriting the same value is harmless.
   assign bus.RegWrite_WB        = valid_q & regwrite_q & (dest_q != 5'd0);
   assign bus.RegDestSelected_WB = dest_q;
   assign bus.RegWriteData_WB    = data_q;
   assign bus.RetiredCount       = cnt_q;

`ifdef BYPASS_EN
   // Forward the pending write so decode never reads a stale register in the same cycle.
   assign bus.Reg_Data1_Fwd = (bus.RegWrite_WB && (bus.ReadReg1_ID == dest_q)) ? data_q
                                                                                : bus.Reg_Data1_RF;
   assign bus.Reg_Data2_Fwd = (bus.RegWrite_WB && (bus.ReadReg2_ID == dest_q)) ? data_q
                                                                                : bus.Reg_Data2_RF;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// tb/tb_writeback_stage.sv - randomized self-checking bench for writeback_stage
module tb_writeback_stage;

   logic Clock = 1'b0;
   logic Reset;

   always #5 Clock = ~Clock;

   writeback_stage_if #(.CNT_W(32)) bus ();
   writeback_stage_if #(.CNT_W(4))  sbus ();

   writeback_stage #(.DATA_W(32), .CNT_W(32)) dut (
      .Clock (Clock),
      .Reset (Reset),
      .bus   (bus)
   );

   // Narrow-counter twin sharing the same stimulus, used to observe wrap-around.
   writeback_stage #(.DATA_W(32), .CNT_W(4)) dut_w4 (
      .Clock (Clock),
      .Reset (Reset),
      .bus   (sbus)
   );

   assign sbus.Stall               = bus.Stall;
   assign sbus.Flush               = bus.Flush;
   assign sbus.Valid_MEM           = bus.Valid_MEM;
   assign sbus.RegWrite_MEM        = bus.RegWrite_MEM;
   assign sbus.MemToReg_MEM        = bus.MemToReg_MEM;
   assign sbus.R_Width_MEM         = bus.R_Width_MEM;
   assign sbus.LoadUnsigned_MEM    = bus.LoadUnsigned_MEM;
   assign sbus.RegDestSelected_MEM = bus.RegDestSelected_MEM;
   assign sbus.ALUResult_MEM       = bus.ALUResult_MEM;
   assign sbus.ReadData_MEM        = bus.ReadData_MEM;
`ifdef BYPASS_EN
   assign sbus.ReadReg1_ID         = bus.ReadReg1_ID;
   assign sbus.ReadReg2_ID         = bus.ReadReg2_ID;
   assign sbus.Reg_Data1_RF        = bus.Reg_Data1_RF;
   assign sbus.Reg_Data2_RF        = bus.Reg_Data2_RF;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   // Reference state: what the MEM/WB register should hold after each edge.
   logic        m_valid, m_rw, m_was_reset;
   logic [4:0]  m_dest;
   logic [31:0] m_data;
   logic [31:0] m_cnt;
   logic [3:0]  m_cnt_s;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   // Write data from the load rules, using shifts and masks over the whole word.
   function automatic logic [31:0] exp_wdata(input logic mtr, input logic [1:0] w,
                                             input logic uns, input logic [31:0] a,
                                             input logic [31:0] rd);
      logic [31:0] v;
      if (!mtr) return a;
      if (w == 2'b01) begin
         v = (rd >> (16 * a[1])) & 32'h0000FFFF;
         if (!uns && v[15]) v = v | 32'hFFFF0000;
         return v;
      end
      if (w == 2'b10) begin
         v = (rd >> (8 * a[1:0])) & 32'h000000FF;
         if (!uns && v[7]) v = v | 32'hFFFFFF00;
         return v;
      end
      return rd;
   endfunction

   task automatic rand_mem();
      bus.Valid_MEM           = 1'($urandom_range(0, 1));
      bus.RegWrite_MEM        = 1'($urandom_range(0, 1));
      bus.MemToReg_MEM        = 1'($urandom_range(0, 1));
      bus.R_Width_MEM         = 2'($urandom_range(0, 3));
      bus.LoadUnsigned_MEM    = 1'($urandom_range(0, 1));
      bus.RegDestSelected_MEM = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      bus.ALUResult_MEM       = $urandom;
      bus.ReadData_MEM        = $urandom;
   endtask

   task automatic set_op(input logic v, input logic rw, input logic mtr, input logic [1:0] w,
                         input logic uns, input logic [4:0] d, input logic [31:0] a,
                         input logic [31:0] rd);
      bus.Valid_MEM = v;           bus.RegWrite_MEM = rw;  bus.MemToReg_MEM = mtr;
      bus.R_Width_MEM = w;         bus.LoadUnsigned_MEM = uns;
      bus.RegDestSelected_MEM = d; bus.ALUResult_MEM = a;  bus.ReadData_MEM = rd;
   endtask

   // Advance one edge: update the model from the inputs in force, then compare.
   task automatic tick();
      logic        e_rw;
      if (!Reset) begin
         m_valid = 1'b0; m_rw = 1'b0; m_dest = 5'd0; m_data = 32'd0;
         m_cnt = 32'd0;  m_cnt_s = 4'd0; m_was_reset = 1'b1;
      end else begin
         m_was_reset = 1'b0;
         if (bus.Flush) begin
            m_valid = 1'b0;
         end else if (!bus.Stall) begin
            m_valid = bus.Valid_MEM;
            m_rw    = bus.RegWrite_MEM;
            m_dest  = bus.RegDestSelected_MEM;
            m_data  = exp_wdata(bus.MemToReg_MEM, bus.R_Width_MEM, bus.LoadUnsigned_MEM,
                                bus.ALUResult_MEM, bus.ReadData_MEM);
            if (bus.Valid_MEM) begin
               m_cnt   = m_cnt + 32'd1;
               m_cnt_s = m_cnt_s + 4'd1;
            end
         end
      end
      @(posedge Clock);
      #1;
      e_rw = m_valid && m_rw && (m_dest != 5'd0);
      check("regwrite", 32'(bus.RegWrite_WB), 32'(e_rw));
      check("retired", bus.RetiredCount, m_cnt);
      check("retired_w4", 32'(sbus.RetiredCount), 32'(m_cnt_s));
      if (e_rw || m_was_reset) begin
         check("dest", 32'(bus.RegDestSelected_WB), 32'(m_dest));
         check("wdata", bus.RegWriteData_WB, m_data);
      end
`ifdef BYPASS_EN
      bus.ReadReg1_ID  = $urandom_range(0, 1) ? m_dest : 5'($urandom_range(0, 31));
      bus.ReadReg2_ID  = $urandom_range(0, 1) ? m_dest : 5'($urandom_range(0, 31));
      bus.Reg_Data1_RF = $urandom;
      bus.Reg_Data2_RF = $urandom;
      #1;
      check("fwd1", bus.Reg_Data1_Fwd,
            (e_rw && bus.ReadReg1_ID == m_dest) ? m_data : bus.Reg_Data1_RF);
      check("fwd2", bus.Reg_Data2_Fwd,
            (e_rw && bus.ReadReg2_ID == m_dest) ? m_data : bus.Reg_Data2_RF);
`endif
   endtask

   initial begin
      m_valid = 1'b0; m_rw = 1'b0; m_dest = 5'd0; m_data = 32'd0;
      m_cnt = 32'd0;  m_cnt_s = 4'd0; m_was_reset = 1'b0;
`ifdef BYPASS_EN
      bus.ReadReg1_ID = 5'd0; bus.ReadReg2_ID = 5'd0;
      bus.Reg_Data1_RF = 32'd0; bus.Reg_Data2_RF = 32'd0;
`endif
      // Reset held for two edges with random inputs.
      Reset = 1'b0;
      for (int i = 0; i < 2; i++) begin
         rand_mem();
         bus.Stall = 1'($urandom_range(0, 1));
         bus.Flush = 1'($urandom_range(0, 1));
         tick();
      end
      check("rst_regwrite", 32'(bus.RegWrite_WB), 32'd0);
      check("rst_dest", 32'(bus.RegDestSelected_WB), 32'd0);
      check("rst_wdata", bus.RegWriteData_WB, 32'd0);
      check("rst_retired", bus.RetiredCount, 32'd0);

      Reset = 1'b1; bus.Stall = 1'b0; bus.Flush = 1'b0;

      set_op(1, 1, 0, 2'b00, 0, 5'd8, 32'h12345678, $urandom);
      tick();
      check("word_rw", 32'(bus.RegWrite_WB), 32'd1);
      check("word_dest", 32'(bus.RegDestSelected_WB), 32'd8);
      check("word_data", bus.RegWriteData_WB, 32'h12345678);
      check("word_cnt", bus.RetiredCount, 32'd1);

      set_op(1, 1, 1, 2'b10, 0, 5'd3, 32'h00001003, 32'h80FF7F01);
      tick();
      check("lb_signed", bus.RegWriteData_WB, 32'hFFFFFF80);
      set_op(1, 1, 1, 2'b10, 1, 5'd3, 32'h00001003, 32'h80FF7F01);
      tick();
      check("lbu", bus.RegWriteData_WB, 32'h00000080);
      set_op(1, 1, 1, 2'b01, 0, 5'd4, 32'h00002003, 32'h80011234);
      tick();
      check("lh_signed", bus.RegWriteData_WB, 32'hFFFF8001);

      set_op(1, 1, 0, 2'b00, 0, 5'd0, 32'hDEADBEEF, 32'h0);
      tick();
      check("x0_rw", 32'(bus.RegWrite_WB), 32'd0);
      check("x0_cnt", bus.RetiredCount, 32'd5);

      set_op(1, 1, 0, 2'b00, 0, 5'd5, 32'hA5A5_0005, 32'h0);
      tick();
      bus.Stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         rand_mem();
         tick();
         check("stall_dest", 32'(bus.RegDestSelected_WB), 32'd5);
         check("stall_data", bus.RegWriteData_WB, 32'hA5A5_0005);
         check("stall_rw", 32'(bus.RegWrite_WB), 32'd1);
         check("stall_cnt", bus.RetiredCount, 32'd6);
      end
      bus.Flush = 1'b1;
      tick();
      check("flush_rw", 32'(bus.RegWrite_WB), 32'd0);
      check("flush_cnt", bus.RetiredCount, 32'd6);
      bus.Stall = 1'b0; bus.Flush = 1'b0;

`ifdef BYPASS_EN
      set_op(1, 1, 0, 2'b00, 0, 5'd9, 32'hCAFEF00D, 32'h0);
      tick();
      bus.ReadReg1_ID = 5'd9; bus.Reg_Data1_RF = 32'd0;
      #1;
      check("byp_hit", bus.Reg_Data1_Fwd, 32'hCAFEF00D);
      bus.ReadReg1_ID = 5'd10; bus.Reg_Data1_RF = 32'h1357_9BDF;
      #1;
      check("byp_miss", bus.Reg_Data1_Fwd, 32'h1357_9BDF);
`endif

      // Counter wrap on the 4-bit twin: 15 retirements reach all-ones, one more wraps to 0.
      Reset = 1'b0;
      tick();
      Reset = 1'b1;
      for (int i = 0; i < 15; i++) begin
         rand_mem();
         bus.Valid_MEM = 1'b1;
         tick();
      end
      check("w4_allones", 32'(sbus.RetiredCount), 32'd15);
      rand_mem();
      bus.Valid_MEM = 1'b1;
      tick();
      check("w4_wrap", 32'(sbus.RetiredCount), 32'd0);
      check("w32_16", bus.RetiredCount, 32'd16);

      // Random mix of captures, stalls, flushes and occasional resets.
      for (int i = 0; i < 400; i++) begin
         rand_mem();
         Reset     = ($urandom_range(0, 63) != 0);
         bus.Stall = ($urandom_range(0, 7) == 0);
         bus.Flush = ($urandom_range(0, 15) == 0);
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
